// File: rtl/eth_rx_audio_buf.sv
// UDP-rx byte stream -> 16-bit big-endian samples -> two-bank ping-pong buffer -> one sample per rd_req.
// A bank is handed over only when full; the writer and the reader each alternate banks 0,1,0,...
module eth_rx_audio_buf #(
  parameter int SAMPLES_PER_BANK = 256,
  parameter int ADDR_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_en,
  input  logic        rx_pkt_done,
  input  logic        rd_req,
  output logic [15:0] sample_out,
  output logic        sample_vld,
  output logic [1:0]  bank_full,
  output logic        underrun,
  output logic        overflow
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SAMPLES_PER_BANK - 1);

  typedef enum logic {HI, LO} phase_t;

  phase_t            phase;
  logic [7:0]        msb;
  logic              wb, rb;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [15:0]       mem [0:2*SAMPLES_PER_BANK-1];

  logic       wr_try, wr_ok, rd_ok, wr_last, rd_last;
  logic [1:0] set_mask, clr_mask;

  // Both sides look at the flags as registered at the start of the cycle.
  assign wr_try   = (phase == LO) && rx_en;
  assign wr_ok    = wr_try && !bank_full[wb];
  assign rd_ok    = rd_req && bank_full[rb];
  assign wr_last  = wr_ok && (waddr == LAST);
  assign rd_last  = rd_ok && (raddr == LAST);
  assign set_mask = wr_last ? (2'b01 << wb) : 2'b00;
  assign clr_mask = rd_last ? (2'b01 << rb) : 2'b00;

  // Storage has no reset; the flags define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[{wb, waddr}] <= {msb, rx_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= HI;
      msb   <= 8'h00;
    end else begin
      if (rx_en) begin
        if (phase == HI) begin
          msb   <= rx_data;
          phase <= LO;
        end else begin
          phase <= HI;
        end
      end
      // End of packet wins over the byte just processed: a lone MSB is dropped.
      if (rx_pkt_done) phase <= HI;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb        <= 1'b0;
      waddr     <= '0;
      rb        <= 1'b0;
      raddr     <= '0;
      bank_full <= 2'b00;
      overflow  <= 1'b0;
    end else begin
      overflow  <= wr_try && bank_full[wb];
      bank_full <= (bank_full | set_mask) & ~clr_mask;
      if (wr_ok) begin
        waddr <= wr_last ? '0 : waddr + 1'b1;
        if (wr_last) wb <= ~wb;
      end
      if (rd_ok) begin
        raddr <= rd_last ? '0 : raddr + 1'b1;
        if (rd_last) rb <= ~rb;
      end
    end
  end

  // Synchronous read port; output holds between requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_out <= 16'h0000;
      sample_vld <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      sample_vld <= rd_req;
      underrun   <= rd_req && !bank_full[rb];
      if (rd_req) sample_out <= rd_ok ? mem[{rb, raddr}] : 16'h0000;
    end
  end
endmodule

// File: tb/tb_eth_rx_audio_buf.sv
// Directed bench for eth_rx_audio_buf: queue-based reference model checked every cycle,
// plus hand-computed literal checks per scenario.
module tb_eth_rx_audio_buf;
  localparam int SPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_en = 1'b0, rx_pkt_done = 1'b0, rd_req = 1'b0;
  logic [15:0] sample_out;
  logic        sample_vld, underrun, overflow;
  logic [1:0]  bank_full;

  int checks = 0, errors = 0;
  bit cmp_on = 0;

  eth_rx_audio_buf #(.SAMPLES_PER_BANK(SPB), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_en(rx_en), .rx_pkt_done(rx_pkt_done),
    .rd_req(rd_req), .sample_out(sample_out), .sample_vld(sample_vld),
    .bank_full(bank_full), .underrun(underrun), .overflow(overflow));

  always #5 clk = ~clk;

  // Reference model: samples flow into a filling bank; a completed bank joins the readable
  // queue; at most two banks exist, so writes drop while two are full.
  bit          m_lo;
  logic [7:0]  m_msb;
  logic [15:0] wq[$];
  logic [15:0] rdq[$];
  int          fulls;
  bit          m_rb;
  logic [15:0] e_out;
  bit          e_vld, e_und, e_ovf;
  int          fs, inc, dec;

  function automatic logic [1:0] e_full();
    if (fulls == 0) return 2'b00;
    if (fulls == 2) return 2'b11;
    return m_rb ? 2'b10 : 2'b01;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lo = 0; m_msb = 0; wq.delete(); rdq.delete(); fulls = 0; m_rb = 0;
      e_out = 0; e_vld = 0; e_und = 0; e_ovf = 0;
    end else begin
      fs = fulls; inc = 0; dec = 0;
      e_vld = rd_req; e_und = 0; e_ovf = 0;
      if (rd_req) begin
        if (fs > 0) begin
          e_out = rdq.pop_front();
          if (rdq.size() % SPB == 0) begin dec = 1; m_rb = !m_rb; end
        end else begin
          e_out = 0; e_und = 1;
        end
      end
      if (rx_en) begin
        if (!m_lo) begin
          m_msb = rx_data; m_lo = 1;
        end else begin
          m_lo = 0;
          if (fs == 2) e_ovf = 1;
          else begin
            wq.push_back({m_msb, rx_data});
            if (wq.size() == SPB) begin
              foreach (wq[i]) rdq.push_back(wq[i]);
              wq.delete(); inc = 1;
            end
          end
        end
      end
      if (rx_pkt_done) m_lo = 0;
      fulls = fs + inc - dec;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model.sample_vld", {15'd0, sample_vld}, {15'd0, e_vld});
      chk("model.sample_out", sample_out, e_out);
      chk("model.bank_full", {14'd0, bank_full}, {14'd0, e_full()});
      chk("model.underrun", {15'd0, underrun}, {15'd0, e_und});
      chk("model.overflow", {15'd0, overflow}, {15'd0, e_ovf});
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge that consumed it.
  task automatic cyc(input bit en, input logic [7:0] d, input bit done, input bit rd);
    rx_en = en; rx_data = d; rx_pkt_done = done; rd_req = rd;
    @(posedge clk); #1;
    rx_en = 0; rx_data = 0; rx_pkt_done = 0; rd_req = 0;
  endtask

  task automatic send(input logic [15:0] s);
    cyc(1, s[15:8], 0, 0);
    cyc(1, s[7:0], 0, 0);
  endtask

  task automatic rd(output logic [15:0] v);
    cyc(0, 8'h00, 0, 1);
    v = sample_out;
  endtask

  task automatic do_reset();
    rst = 1; #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    cmp_on = 1;
  endtask

  task automatic case1();
    logic [15:0] exp_v [4];
    logic [15:0] v;
    exp_v[0] = 16'h1234; exp_v[1] = 16'h5678; exp_v[2] = 16'h9ABC; exp_v[3] = 16'hDEF0;
    send(16'h1234); send(16'h5678); send(16'h9ABC); send(16'hDEF0);
    chk("c1.full_after_fill", {14'd0, bank_full}, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      rd(v);
      chk("c1.vld", {15'd0, sample_vld}, 16'h0001);
      chk("c1.data", v, exp_v[i]);
    end
    chk("c1.full_after_drain", {14'd0, bank_full}, 16'h0000);
  endtask

  initial begin
    logic [15:0] v;
    do_reset();

    // 1: basic fill and drain
    case1();

    // 2: underrun straight after reset, then a full bank reads from addr 0
    do_reset();
    rd(v);
    chk("c2.vld", {15'd0, sample_vld}, 16'h0001);
    chk("c2.out", v, 16'h0000);
    chk("c2.underrun", {15'd0, underrun}, 16'h0001);
    send(16'hA001); send(16'hA002); send(16'hA003); send(16'hA004);
    rd(v);
    chk("c2.first", v, 16'hA001);
    rd(v); rd(v); rd(v);
    chk("c2.last", v, 16'hA004);

    // 3: 16 samples, no reads; second eight overflow
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      send(16'h0101 * 16'(i));
      if (i == 8) chk("c3.full11", {14'd0, bank_full}, 16'h0003);
      if (i > 8) chk("c3.overflow", {15'd0, overflow}, 16'h0001);
    end
    for (int i = 1; i <= 8; i++) begin
      rd(v);
      chk("c3.readback", v, 16'h0101 * 16'(i));
    end

    // 4: packet boundary discards a lone MSB
    do_reset();
    cyc(1, 8'hAA, 0, 0);
    cyc(0, 8'h00, 1, 0);
    send(16'h1122);
    cyc(1, 8'hAA, 1, 0);
    send(16'hBBCC);
    send(16'h0001); send(16'h0002);
    rd(v); chk("c4.s0", v, 16'h1122);
    rd(v); chk("c4.s1", v, 16'hBBCC);
    rd(v); rd(v);

    // 5: write hits bank0 in the cycle the reader frees it
    do_reset();
    for (int i = 1; i <= 8; i++) send(16'h5500 + 16'(i));
    rd(v); rd(v); rd(v);
    cyc(1, 8'h77, 0, 0);
    cyc(1, 8'h88, 0, 1);
    chk("c5.overflow", {15'd0, overflow}, 16'h0001);
    chk("c5.read4", sample_out, 16'h5504);
    chk("c5.full10", {14'd0, bank_full}, 16'h0002);
    send(16'h6601);
    chk("c5.no_ovf", {15'd0, overflow}, 16'h0000);
    send(16'h6602); send(16'h6603); send(16'h6604);
    chk("c5.full11", {14'd0, bank_full}, 16'h0003);
    for (int i = 5; i <= 8; i++) begin rd(v); chk("c5.bank1", v, 16'h5500 + 16'(i)); end
    rd(v); chk("c5.bank0_addr0", v, 16'h6601);
    rd(v); rd(v); rd(v);

    // 6: async reset mid-fill with a read in flight
    do_reset();
    for (int i = 1; i <= 6; i++) send(16'h7700 + 16'(i));
    rd(v);
    chk("c6.pre_vld", {15'd0, sample_vld}, 16'h0001);
    rd_req = 1; rx_en = 1; rx_data = 8'h99;
    #1 rst = 1;
    #1;
    chk("c6.rst_out", sample_out, 16'h0000);
    chk("c6.rst_vld", {15'd0, sample_vld}, 16'h0000);
    chk("c6.rst_full", {14'd0, bank_full}, 16'h0000);
    chk("c6.rst_und", {15'd0, underrun}, 16'h0000);
    chk("c6.rst_ovf", {15'd0, overflow}, 16'h0000);
    rd_req = 0; rx_en = 0; rx_data = 0;
    @(posedge clk); #1;
    rst = 0;
    case1();

    cyc(0, 8'h00, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
